// File: rtl/disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_pkg : shared FSM states and 7-segment glyphs (active-low gfedcba)|
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } disp_state_e;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Index 0 is the rightmost entry so SEG_HEX[n] yields the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin2bcd_seq : 8-bit binary to 3-digit BCD, one double-dabble step/clk |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [7:0]  Bin,
  output logic        Busy,
  output logic        Done,
  output logic [11:0] Bcd
);

  disp_state_e state_q, state_d;
  logic [19:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] adj;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    adj     = sh_q;
    for (int i = 0; i < 3; i++) begin
      if (sh_q[8 + 4*i +: 4] >= 4'd5) adj[8 + 4*i +: 4] = sh_q[8 + 4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (Start) begin
          sh_d    = {12'h000, Bin};
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = {adj[18:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);
  assign Bcd  = sh_q[19:8];

endmodule
`default_nettype wire

// File: rtl/temp_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | temp_display : 4-digit muxed 7-seg, signed decimal temp or hex switch |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module temp_display
  import disp_pkg::*;
#(
  parameter int FREQ_CLK   = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Temp,
  input  logic [7:0] Switches,
  input  logic       Disp_Sel,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [3:0] An,
  output logic       Busy,
  output logic       Value_Valid
);

  localparam int DIV   = FREQ_CLK / (REFRESH_HZ * DIGITS);
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [7:0] temp_q, temp_d, switches_q, switches_d, last_q, last_d;
  logic       force_q, force_d, sign_q, sign_d, vv_q, vv_d;
  logic [DIGITS-1:0][6:0] disp_q, disp_d, sw_glyph;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        cvt_start, cvt_busy, cvt_done;
  logic [7:0]  mag;
  logic [11:0] bcd;

  bin2bcd_seq u_bcd (
    .Clk  (Clk),
    .Rst  (Rst),
    .Start(cvt_start),
    .Bin  (mag),
    .Busy (cvt_busy),
    .Done (cvt_done),
    .Bcd  (bcd)
  );

  assign mag       = temp_q[7] ? (~temp_q + 8'd1) : temp_q;
  assign cvt_start = !cvt_busy && (force_q || (temp_q != last_q));
  assign sw_glyph  = {SEG_BLANK, SEG_BLANK, SEG_HEX[switches_q[7:4]], SEG_HEX[switches_q[3:0]]};

  always_comb begin
    temp_d     = Temp;
    switches_d = Switches;
    last_d     = last_q;
    force_d    = force_q;
    sign_d     = sign_q;
    disp_d     = disp_q;
    vv_d       = cvt_done;
    pre_d      = pre_q + 1'b1;
    idx_d      = idx_q;
    seg_d      = seg_q;
    an_d       = an_q;
    if (cvt_start) begin
      last_d  = temp_q;
      force_d = 1'b0;
      sign_d  = temp_q[7];
    end
    // Leading-zero blanking is resolved here so the scan path only muxes glyphs.
    if (cvt_done) begin
      disp_d[3] = sign_q ? SEG_MINUS : SEG_BLANK;
      disp_d[2] = (bcd[11:8] == 4'd0) ? SEG_BLANK : SEG_HEX[bcd[11:8]];
      disp_d[1] = (bcd[11:4] == 8'd0) ? SEG_BLANK : SEG_HEX[bcd[7:4]];
      disp_d[0] = SEG_HEX[bcd[3:0]];
    end
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
      an_d  = ~(4'b0001 << idx_d);
      seg_d = Disp_Sel ? sw_glyph[idx_d] : disp_q[idx_d];
    end
  end

  always_ff @(posedge Clk) begin
    temp_q     <= temp_d;
    switches_q <= switches_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_q  <= 8'h00;
      force_q <= 1'b1;
      sign_q  <= 1'b0;
      disp_q  <= {DIGITS{SEG_BLANK}};
      vv_q    <= 1'b0;
      pre_q   <= '0;
      idx_q   <= 2'd0;
      seg_q   <= SEG_BLANK;
      an_q    <= 4'hF;
    end else begin
      last_q  <= last_d;
      force_q <= force_d;
      sign_q  <= sign_d;
      disp_q  <= disp_d;
      vv_q    <= vv_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign Seg         = seg_q;
  assign An          = an_q;
  assign Dp          = 1'b1;
  assign Busy        = cvt_busy;
  assign Value_Valid = vv_q;

endmodule
`default_nettype wire
